// File: rtl/fdiv_iter_if.sv
// Valid/ready request/response bundle for the iterative FP32 divider.
// The flags field exists only when FDIV_ITER_IEEE_EN is defined.
interface fdiv_iter_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      x1;
  logic [31:0]      x2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      y;
  logic [TAG_W-1:0] out_tag;
`ifdef FDIV_ITER_IEEE_EN
  logic [2:0]       flags;

  modport master (
    output in_valid, x1, x2, in_tag, out_ready,
    input  in_ready, out_valid, y, out_tag, flags
  );
  modport slave (
    input  in_valid, x1, x2, in_tag, out_ready,
    output in_ready, out_valid, y, out_tag, flags
  );
`else
  modport master (
    output in_valid, x1, x2, in_tag, out_ready,
    input  in_ready, out_valid, y, out_tag
  );
  modport slave (
    input  in_valid, x1, x2, in_tag, out_ready,
    output in_ready, out_valid, y, out_tag
  );
`endif
endinterface

// File: rtl/fdiv_iter.sv
// Multi-cycle FP32 divider: restoring long division, RADIX_LOG2 quotient bits per clock.
// Define FDIV_ITER_IEEE_EN for NaN/inf handling and the {invalid,divzero,overflow} flags.
module fdiv_iter #(
  parameter int RADIX_LOG2 = 1,
  parameter int TAG_W      = 5
) (
  input  logic       clk,
  input  logic       rstn,
  fdiv_iter_if.slave bus
);
  localparam int         N    = 48 / RADIX_LOG2;
  localparam logic [5:0] LAST = 6'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] SP_NONE = 2'd0;
  localparam logic [1:0] SP_ZERO = 2'd1;
  localparam logic [1:0] SP_INF  = 2'd2;
  localparam logic [1:0] SP_NAN  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             sign_q, sign_d;
  logic [7:0]       ee1_q, ee1_d, ee2_q, ee2_d;
  logic [23:0]      m2_q, m2_d;
  logic [47:0]      dvd_q, dvd_d, rem_q, rem_d, quo_q, quo_d;
  logic [1:0]       sp_q, sp_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      y_q, y_d;
`ifdef FDIV_ITER_IEEE_EN
  logic [2:0]       spf_q, spf_d, flags_q, flags_d;
`endif

  // Operand classification, evaluated on the accept cycle only.
  logic [7:0] e1, e2;
  logic       z1, z2;
  logic [1:0] sp_in;
`ifdef FDIV_ITER_IEEE_EN
  logic       i1, i2, n1, n2;
  logic [2:0] spf_in;
`endif
  always_comb begin
    e1    = bus.x1[30:23];
    e2    = bus.x2[30:23];
    z1    = (bus.x1[30:0] == 31'd0);
    z2    = (bus.x2[30:0] == 31'd0);
    sp_in = SP_NONE;
`ifdef FDIV_ITER_IEEE_EN
    i1     = (e1 == 8'hFF) && (bus.x1[22:0] == 23'd0);
    i2     = (e2 == 8'hFF) && (bus.x2[22:0] == 23'd0);
    n1     = (e1 == 8'hFF) && (bus.x1[22:0] != 23'd0);
    n2     = (e2 == 8'hFF) && (bus.x2[22:0] != 23'd0);
    spf_in = 3'b000;
    if (n1 || n2 || (z1 && z2) || (i1 && i2)) begin
      sp_in  = SP_NAN;
      spf_in = 3'b100;
    end else if (z2) begin
      sp_in  = SP_INF;
      spf_in = i1 ? 3'b000 : 3'b010;
    end else if (i1) begin
      sp_in = SP_INF;
    end else if (i2 || z1) begin
      sp_in = SP_ZERO;
    end
`else
    if (z2)      sp_in = SP_INF;
    else if (z1) sp_in = SP_ZERO;
`endif
  end

  // NOTE: blocking assignments are correct here -- each chained step must see the previous
  // step's remainder within the same cycle; registers themselves only change in always_ff.
  logic [47:0] step_rem, step_dvd, step_quo;
  always_comb begin
    step_rem = rem_q;
    step_dvd = dvd_q;
    step_quo = quo_q;
    for (int k = 0; k < RADIX_LOG2; k++) begin
      step_rem = {step_rem[46:0], step_dvd[47]};
      step_dvd = {step_dvd[46:0], 1'b0};
      step_quo = {step_quo[46:0], 1'b0};
      if (step_rem >= {24'd0, m2_q}) begin
        step_rem    = step_rem - {24'd0, m2_q};
        step_quo[0] = 1'b1;
      end
    end
  end

  logic rnd;
  assign rnd = ({rem_q, 1'b0} >= {25'd0, m2_q});

  // Packing of the rounded quotient held in quo_q during the second NORM cycle.
  logic [5:0]        lead;
  logic signed [9:0] e_crude;
  logic [22:0]       frac23;
  logic [9:0]        den_sh;
  logic [31:0]       pack_y, fin_y;
  logic              pack_ovf;
  always_comb begin
    lead = 6'd0;
    for (int i = 0; i < 48; i++) begin
      if (quo_q[i]) lead = 6'(i);
    end
    e_crude  = $signed({2'b00, ee1_q}) - $signed({2'b00, ee2_q})
             + $signed({4'b0000, lead}) + 10'sd103;
    frac23   = 23'((quo_q << (6'd47 - lead)) >> 24);
    den_sh   = 10'(10'sd1 - e_crude);
    pack_ovf = 1'b0;
    if (e_crude >= 10'sd255) begin
      pack_y   = {sign_q, 8'hFF, 23'd0};
      pack_ovf = 1'b1;
    end else if (e_crude >= 10'sd1) begin
      pack_y = {sign_q, e_crude[7:0], frac23};
    end else if (den_sh >= 10'd24) begin
      pack_y = {sign_q, 31'd0};
    end else begin
      pack_y = {sign_q, 8'd0, 23'({1'b1, frac23} >> den_sh[4:0])};
    end
    case (sp_q)
      SP_ZERO: fin_y = {sign_q, 31'd0};
      SP_INF:  fin_y = {sign_q, 8'hFF, 23'd0};
      SP_NAN:  fin_y = 32'h7FC0_0000;
      default: fin_y = pack_y;
    endcase
  end

  // NOTE: every next-state signal takes its hold value first, so no branch can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    sign_d  = sign_q;
    ee1_d   = ee1_q;
    ee2_d   = ee2_q;
    m2_d    = m2_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    sp_d    = sp_q;
    tag_d   = tag_q;
    y_d     = y_q;
`ifdef FDIV_ITER_IEEE_EN
    spf_d   = spf_q;
    flags_d = flags_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_DIV;
          cnt_d   = 6'd0;
          phase_d = 1'b0;
          sign_d  = bus.x1[31] ^ bus.x2[31];
          ee1_d   = (e1 == 8'd0) ? 8'd1 : e1;
          ee2_d   = (e2 == 8'd0) ? 8'd1 : e2;
          m2_d    = {e2 != 8'd0, bus.x2[22:0]};
          dvd_d   = {e1 != 8'd0, bus.x1[22:0], 24'd0};
          rem_d   = 48'd0;
          quo_d   = 48'd0;
          sp_d    = sp_in;
          tag_d   = bus.in_tag;
`ifdef FDIV_ITER_IEEE_EN
          spf_d   = spf_in;
`endif
        end
      end
      S_DIV: begin
        rem_d = step_rem;
        dvd_d = step_dvd;
        quo_d = step_quo;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST) state_d = S_NORM;
      end
      S_NORM: begin
        if (!phase_q) begin
          quo_d   = quo_q + {47'd0, rnd};
          phase_d = 1'b1;
        end else begin
          y_d     = fin_y;
`ifdef FDIV_ITER_IEEE_EN
          flags_d = (sp_q == SP_NONE) ? {2'b00, pack_ovf} : spf_q;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so a reset abandons the division and leaves
  // nothing of it visible on y/out_tag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      phase_q <= 1'b0;
      sign_q  <= 1'b0;
      ee1_q   <= 8'd0;
      ee2_q   <= 8'd0;
      m2_q    <= 24'd0;
      dvd_q   <= 48'd0;
      rem_q   <= 48'd0;
      quo_q   <= 48'd0;
      sp_q    <= SP_NONE;
      tag_q   <= '0;
      y_q     <= 32'd0;
`ifdef FDIV_ITER_IEEE_EN
      spf_q   <= 3'b000;
      flags_q <= 3'b000;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      sign_q  <= sign_d;
      ee1_q   <= ee1_d;
      ee2_q   <= ee2_d;
      m2_q    <= m2_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      sp_q    <= sp_d;
      tag_q   <= tag_d;
      y_q     <= y_d;
`ifdef FDIV_ITER_IEEE_EN
      spf_q   <= spf_d;
      flags_q <= flags_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.y         = y_q;
  assign bus.out_tag   = tag_q;
`ifdef FDIV_ITER_IEEE_EN
  assign bus.flags     = flags_q;
`endif
endmodule

// File: tb/tb_fdiv_iter.sv
// Bench for fdiv_iter: radix-2 and radix-16 instances, an arithmetic reference model with a
// scoreboard compared on every valid output cycle, and directed literal vectors.
module tb_fdiv_iter;
  localparam int TAG_W = 5;

  logic             clk, rstn;
  logic             in_valid, out_ready;
  logic [31:0]      x1, x2;
  logic [TAG_W-1:0] in_tag;
  int               sel;
  int               checks, failures, cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fdiv_iter_if #(.TAG_W(TAG_W)) bus1 ();
  fdiv_iter_if #(.TAG_W(TAG_W)) bus4 ();

  assign bus1.in_valid  = in_valid && (sel == 0);
  assign bus1.x1        = x1;
  assign bus1.x2        = x2;
  assign bus1.in_tag    = in_tag;
  assign bus1.out_ready = out_ready && (sel == 0);
  assign bus4.in_valid  = in_valid && (sel == 1);
  assign bus4.x1        = x1;
  assign bus4.x2        = x2;
  assign bus4.in_tag    = in_tag;
  assign bus4.out_ready = out_ready && (sel == 1);

  fdiv_iter #(.RADIX_LOG2(1), .TAG_W(TAG_W)) u_dut1 (.clk(clk), .rstn(rstn), .bus(bus1));
  fdiv_iter #(.RADIX_LOG2(4), .TAG_W(TAG_W)) u_dut4 (.clk(clk), .rstn(rstn), .bus(bus4));

  logic             m_in_ready, m_out_valid;
  logic [31:0]      m_y;
  logic [TAG_W-1:0] m_tag;
  assign m_in_ready  = (sel == 0) ? bus1.in_ready  : bus4.in_ready;
  assign m_out_valid = (sel == 0) ? bus1.out_valid : bus4.out_valid;
  assign m_y         = (sel == 0) ? bus1.y         : bus4.y;
  assign m_tag       = (sel == 0) ? bus1.out_tag   : bus4.out_tag;
`ifdef FDIV_ITER_IEEE_EN
  logic [2:0] m_flags;
  assign m_flags = (sel == 0) ? bus1.flags : bus4.flags;
`endif

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: exact integer division of the significands, then IEEE-style packing.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
    logic              s, za, zb;
    logic [7:0]        ea, eb;
    longint unsigned   ma, mb, num, q, r;
    int                p, e, e1v, e2v, sh;
    logic [23:0]       mant;
    logic [22:0]       den;
    logic [2:0]        ovf;
`ifdef FDIV_ITER_IEEE_EN
    logic              na, nb, ia, ib;
`endif
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    za = (a[30:0] == 31'd0);
    zb = (b[30:0] == 31'd0);
    ovf = 3'b000;
`ifdef FDIV_ITER_IEEE_EN
    ovf = 3'b001;
    na = (ea == 8'hFF) && (a[22:0] != 0);
    nb = (eb == 8'hFF) && (b[22:0] != 0);
    ia = (ea == 8'hFF) && (a[22:0] == 0);
    ib = (eb == 8'hFF) && (b[22:0] == 0);
    if (na || nb || (za && zb) || (ia && ib)) return {3'b100, 32'h7FC00000};
    if (zb) return {(ia ? 3'b000 : 3'b010), s, 8'hFF, 23'd0};
    if (ia) return {3'b000, s, 8'hFF, 23'd0};
    if (ib || za) return {3'b000, s, 31'd0};
`else
    if (zb) return {3'b000, s, 8'hFF, 23'd0};
    if (za) return {3'b000, s, 31'd0};
`endif
    ma  = {40'd0, (ea != 8'd0), a[22:0]};
    mb  = {40'd0, (eb != 8'd0), b[22:0]};
    num = ma << 24;
    q   = num / mb;
    r   = num % mb;
    if (2 * r >= mb) q = q + 1;
    p = 0;
    for (int i = 0; i < 48; i++) if (q[i]) p = i;
    e1v = (ea == 8'd0) ? 1 : int'(ea);
    e2v = (eb == 8'd0) ? 1 : int'(eb);
    e   = e1v - e2v + (p - 24) + 127;
    if (p >= 23) mant = 24'(q >> (p - 23));
    else         mant = 24'(q << (23 - p));
    if (e >= 255) return {ovf, s, 8'hFF, 23'd0};
    if (e >= 1)   return {3'b000, s, 8'(e), mant[22:0]};
    sh  = 1 - e;
    den = (sh >= 24) ? 23'd0 : 23'(mant >> sh);
    return {3'b000, s, 8'd0, den};
  endfunction

  typedef struct {
    logic [31:0]      y;
    logic [2:0]       fl;
    logic [TAG_W-1:0] tag;
    int               acc;
    int               lat;
    bit               seen;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard maintenance: push on accept, pop on result handshake, flush on reset.
  always @(posedge clk) begin
    logic [34:0] m;
    exp_t        it;
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (m_out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && m_in_ready) begin
        m       = model(x1, x2);
        it.y    = m[31:0];
        it.fl   = m[34:32];
        it.tag  = in_tag;
        it.acc  = cyc;
        it.lat  = (sel == 0) ? 50 : 14;
        it.seen = 1'b0;
        exp_q.push_back(it);
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && m_out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_out_valid: got y=%0h with no outstanding request", m_y);
      end else begin
        check("model_y", m_y, exp_q[0].y);
        check("model_tag", m_tag, exp_q[0].tag);
`ifdef FDIV_ITER_IEEE_EN
        check("model_flags", m_flags, exp_q[0].fl);
`endif
        if (!exp_q[0].seen) begin
          check("latency", cyc - 1 - exp_q[0].acc, exp_q[0].lat);
          exp_q[0].seen = 1'b1;
        end
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t,
                        input logic [31:0] lit_y, input int hold);
    int n;
    @(negedge clk);
    x1 = a; x2 = b; in_tag = t; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!m_in_ready && n < 20) begin @(negedge clk); n++; end
    check("accept_wait", m_in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!m_out_valid && n < 200) begin @(negedge clk); n++; end
    check("out_valid_wait", m_out_valid, 1'b1);
    check("lit_y", m_y, lit_y);
    for (int h = 0; h < hold; h++) begin
      check("hold_in_ready", m_in_ready, 1'b0);
      check("hold_y", m_y, lit_y);
      check("hold_tag", m_tag, t);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("busy_in_ready", m_in_ready, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_in_ready", m_in_ready, 1'b1);
    check("out_valid_drop", m_out_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [34:0] pm;
    int          n;
    checks = 0; failures = 0; cyc = 0; sel = 0;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x1 = 0; x2 = 0; in_tag = 0;

    pm = model(32'h40C00000, 32'h40000000); check("pin_6_div_2", pm[31:0], 32'h40400000);
    pm = model(32'h3F800000, 32'h40400000); check("pin_1_div_3", pm[31:0], 32'h3EAAAAAB);
    pm = model(32'h00800000, 32'h40000000); check("pin_denorm", pm[31:0], 32'h00400000);
    pm = model(32'h7F000000, 32'h3E800000); check("pin_ovf", pm[31:0], 32'h7F800000);
`ifdef FDIV_ITER_IEEE_EN
    check("pin_ovf_flag", pm[34:32], 3'b001);
    pm = model(32'h00000000, 32'h00000000); check("pin_0_0_flag", pm[34:32], 3'b100);
`endif

    repeat (3) @(negedge clk);
    check("rst_in_ready", m_in_ready, 1'b1);
    check("rst_out_valid", m_out_valid, 1'b0);
    check("rst_y", m_y, 32'd0);
    check("rst_tag", m_tag, 5'd0);
    rstn = 1'b1;

    run_op(32'h40C00000, 32'h40000000, 5'h01, 32'h40400000, 0);
    run_op(32'h3F800000, 32'h40400000, 5'h02, 32'h3EAAAAAB, 0);
    run_op(32'h00800000, 32'h40000000, 5'h03, 32'h00400000, 0);
    run_op(32'h7F000000, 32'h3E800000, 5'h04, 32'h7F800000, 0);
    run_op(32'hBF800000, 32'h00000000, 5'h05, 32'hFF800000, 0);
`ifdef FDIV_ITER_IEEE_EN
    run_op(32'h00000000, 32'h00000000, 5'h06, 32'h7FC00000, 0);
`else
    run_op(32'h00000000, 32'h00000000, 5'h06, 32'h7F800000, 0);
`endif
    run_op(32'h80000000, 32'h3F800000, 5'h07, 32'h80000000, 0);
    run_op(32'h00000002, 32'h40000000, 5'h08, 32'h00000001, 0);
    run_op(32'h00000001, 32'h40000000, 5'h09, 32'h00000000, 0);
    run_op(32'h3F800000, 32'h3F400000, 5'h0A, 32'h3FAAAAAB, 0);
    run_op(32'h7F800000, 32'h3F800000, 5'h0B, 32'h7F800000, 0);
    run_op(32'h40400000, 32'h3F800000, 5'h13, 32'h40400000, 10);

    // Abandon a division in flight with an asynchronous reset.
    @(negedge clk);
    x1 = 32'h40C00000; x2 = 32'h40000000; in_tag = 5'h1E; in_valid = 1'b1;
    n = 0;
    while (!m_in_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    check("mid_busy", m_in_ready, 1'b0);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_out_valid", m_out_valid, 1'b0);
    check("mid_rst_in_ready", m_in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_op(32'h3F800000, 32'h3F800000, 5'h16, 32'h3F800000, 0);

    @(negedge clk);
    sel = 1;
    run_op(32'h3F800000, 32'h40400000, 5'h14, 32'h3EAAAAAB, 0);
    run_op(32'h40C00000, 32'h40000000, 5'h15, 32'h40400000, 2);

    repeat (3) @(negedge clk);
    check("drain_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
